// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared state encoding and width helpers for bit_serializer
package serializer_pkg;

  typedef logic [0:0] ser_state_t;

  localparam ser_state_t SER_IDLE  = 1'b0;
  localparam ser_state_t SER_SHIFT = 1'b1;

  // Bit counter must index every bit position of a word.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

  // Level has to represent DEPTH itself, hence the extra bit.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - word-in / bit-out handshake bundle for bit_serializer
interface bit_serializer_if
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);

  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH-1:0]              in_data;
  logic                          out;
  logic                          out_valid;
  logic [level_width(DEPTH)-1:0] level;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out,
    input  out_valid,
    input  level
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out,
    output out_valid,
    output level
  );

endinterface

// File: rtl/ser_fifo.sv
// rtl/ser_fifo.sv - synchronous pointer-plus-count FIFO feeding the serializer shifter
module ser_fifo
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head,
  output logic                          full,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Storage carries no reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - queues parallel words and shifts them out one bit per clock
// Build option SERIALIZER_MSB_FIRST_EN selects MSB-first emission; default is LSB-first.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter bit IDLE_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  bit_serializer_if.slave   bus
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] head;
  logic             data_bit;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign bus.in_ready = !fifo_full && !reset;
  assign push         = bus.in_valid && bus.in_ready;

  // Reloading on the last bit keeps consecutive words back-to-back.
  assign pop = !fifo_empty && ((state == SER_IDLE) || (cnt == LAST));

  ser_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.in_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (bus.level)
  );

`ifdef SERIALIZER_MSB_FIRST_EN
  assign data_bit = shreg[WIDTH-1];
  assign shifted  = {shreg[WIDTH-2:0], 1'b0};
`else
  assign data_bit = shreg[0];
  assign shifted  = {1'b0, shreg[WIDTH-1:1]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SER_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        SER_IDLE: begin
          if (pop) begin
            shreg <= head;
            cnt   <= '0;
            state <= SER_SHIFT;
          end
        end
        default: begin
          if (cnt == LAST) begin
            if (pop) begin
              shreg <= head;
              cnt   <= '0;
            end else begin
              state <= SER_IDLE;
            end
          end else begin
            shreg <= shifted;
            cnt   <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.out       = (state == SER_SHIFT) ? data_bit : IDLE_BIT;
  assign bus.out_valid = (state == SER_SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - directed self-checking bench for bit_serializer
module tb_bit_serializer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  bit_serializer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

  bit_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDLE_BIT(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  bit_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDLE_BIT(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  int         checks = 0;
  int         errors = 0;
  logic       bits[$];
  int         runs = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] w3[3] = '{8'h00, 8'hFF, 8'hA5};
  logic [7:0] w6[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  int         n;
  int         low_cycles;
  logic [2:0] lvl_at_full;
  logic       acc;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      bits.push_back(bus.out);
      if (!prev_valid) runs++;
    end
    prev_valid = bus.out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int i);
`ifdef SERIALIZER_MSB_FIRST_EN
    return w[WIDTH-1-i];
`else
    return w[i];
`endif
  endfunction

  function automatic logic [WIDTH-1:0] word_at(input int j);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < WIDTH; i++) begin
`ifdef SERIALIZER_MSB_FIRST_EN
      w[WIDTH-1-i] = bits[j*WIDTH+i];
`else
      w[i] = bits[j*WIDTH+i];
`endif
    end
    return w;
  endfunction

  initial begin
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;
    tick();
    tick();

    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out", bus.out, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_level", bus.level, 3'd0);
    chk("rst_idle1_out", bus1.out, 1'b1);

    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);

    // single word F0
    bits.delete();
    runs = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hF0;
    tick();
    bus.in_valid = 1'b0;
    chk("f0_level_after_push", bus.level, 3'd1);
    chk("f0_not_yet_valid", bus.out_valid, 1'b0);
    tick();
    chk("f0_level_after_pop", bus.level, 3'd0);
    for (int i = 0; i < WIDTH; i++) begin
      chk("f0_valid", bus.out_valid, 1'b1);
      chk("f0_bit", bus.out, exp_bit(8'hF0, i));
      tick();
    end
    chk("f0_done_valid", bus.out_valid, 1'b0);
    chk("f0_done_out", bus.out, 1'b0);
    chk("f0_bits", bits.size(), 8);

    // three words back to back
    bits.delete();
    runs = 0;
    for (int j = 0; j < 3; j++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w3[j];
      tick();
    end
    bus.in_valid = 1'b0;
    chk("b2b_level", bus.level, 3'd2);
    repeat (30) tick();
    chk("b2b_bits", bits.size(), 24);
    chk("b2b_runs", runs, 1);
    for (int j = 0; j < 3; j++) begin
      chk("b2b_word", word_at(j), w3[j]);
    end

    // six words against a four-deep queue
    bits.delete();
    runs = 0;
    n = 0;
    low_cycles = 0;
    lvl_at_full = '0;
    for (int c = 0; c < 100 && n < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w6[n];
      acc = bus.in_ready;
      if (!acc) begin
        low_cycles++;
        if (low_cycles == 1) lvl_at_full = bus.level;
      end
      tick();
      if (acc) n++;
    end
    bus.in_valid = 1'b0;
    chk("full_pushed", n, 6);
    chk("full_level", lvl_at_full, 3'd4);
    chk("full_stall_cycles", low_cycles, 5);
    repeat (50) tick();
    chk("full_bits", bits.size(), 48);
    chk("full_runs", runs, 1);
    for (int j = 0; j < 6; j++) begin
      chk("full_word", word_at(j), w6[j]);
    end
    chk("full_drained_level", bus.level, 3'd0);
    chk("full_drained_ready", bus.in_ready, 1'b1);

    // reset at bit 3 with two words queued
    bits.delete();
    runs = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    tick();
    bus.in_data  = 8'h5A;
    tick();
    bus.in_data  = 8'h96;
    tick();
    bus.in_valid = 1'b0;
    chk("mid_level", bus.level, 3'd2);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_out", bus.out, 1'b0);
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_level", bus.level, 3'd0);
    chk("mid_rst_ready", bus.in_ready, 1'b0);
    chk("mid_bits_before", bits.size(), 4);
    reset = 1'b0;
    bits.delete();
    runs = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    tick();
    bus.in_valid = 1'b0;
    repeat (12) tick();
    chk("fresh_bits", bits.size(), 8);
    chk("fresh_runs", runs, 1);
    chk("fresh_word", word_at(0), 8'hC3);
    chk("fresh_level", bus.level, 3'd0);

    // idle-high instance never saw traffic
    chk("idle1_out", bus1.out, 1'b1);
    chk("idle1_valid", bus1.out_valid, 1'b0);
    chk("idle1_level", bus1.level, 3'd0);
    chk("idle1_ready", bus1.in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Upstream feeder for the serial sequence-detector FSM. The block accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and shifts them out one bit per clock on a single-bit `out` line that drives the detector's `in`. Back-to-back words produce a gapless bit stream. When nothing is queued, the line is held at a defined idle level.

## Interface
- `WIDTH`, default 8: word width in bits; must be ≥ 2.
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and ≥ 2.
- `IDLE_BIT`, default 0: level driven on `out` while no word is being shifted.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  producer presents `in_data`.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  WIDTH  parallel word.
- `out`  out  1  serial bit; connects to the detector's `in`.
- `out_valid`  out  1  `out` carries a data bit this cycle.
- `level`  out  clog2(DEPTH)+1  number of words held in the FIFO, excluding the word being shifted.

## Operation
- Push: a word is accepted on any edge where `in_valid && in_ready`. `in_ready = (level != DEPTH) && !reset`.
- Push while full is not allowed, even in a cycle that also pops.
- The word is written to the FIFO at the tail; there is no bypass path.
- Shifter FSM has two states, IDLE and SHIFT, plus a bit counter `cnt` (clog2(WIDTH) bits) and a shift register `shreg` (WIDTH bits).
- IDLE → SHIFT when the FIFO is non-empty: pop the head into `shreg`, set `cnt` = 0.
- In SHIFT, each edge shifts `shreg` by one bit and increments `cnt`.
  - When `cnt == WIDTH-1` and the FIFO is non-empty: pop the next word into `shreg`, set `cnt` = 0, stay in SHIFT. This gives zero bubble between words.
  - When `cnt == WIDTH-1` and the FIFO is empty: go to IDLE.
- Output bit is `out = shreg[0]` in SHIFT (LSB-first), and `IDLE_BIT` in IDLE.
- `out_valid = (state == SHIFT)`.
- Push and pop in the same cycle are both performed; `level` stays unchanged.
- Total capacity is DEPTH words queued plus 1 word in flight.

## Timing
- Reset values: state IDLE, `cnt` = 0, FIFO empty, `level` = 0, `out` = `IDLE_BIT`, `out_valid` = 0. `in_ready` = 0 while `reset` is high and 1 in the first cycle after reset.
- Latency, block idle and empty: word accepted at edge k is popped at edge k+1. The first bit is on `out` with `out_valid` = 1 in the cycle after edge k+1, and the last bit WIDTH-1 cycles later.
- Throughput is one word per WIDTH cycles, sustained.
- Reset mid-word: the current word and all queued words are discarded. `out` returns to `IDLE_BIT` after the reset edge.
- `level` and `in_ready` are updated at the same edge as the push or pop that changes them.

## Configuration
- `SERIALIZER_MSB_FIRST_EN` defined: words are emitted MSB-first, with `out = shreg[WIDTH-1]` and a left shift.
- Undefined (the default): words are emitted LSB-first, with `out = shreg[0]` and a right shift.
- Latency, handshake and idle behaviour are identical in both builds.

## Structure
- Package `serializer_pkg` holds:
  - the state typedef (`SER_IDLE`, `SER_SHIFT`);
  - the width-derivation constants (counter and level widths) as functions of `WIDTH`/`DEPTH`.
- One sub-module, `ser_fifo`: synchronous FIFO parameterised by WIDTH/DEPTH with push, pop, head data, full, empty and level. It uses a pointer-plus-count scheme, and the pointers wrap modulo DEPTH.
- The FSM, counter and shift register live in `bit_serializer`.

## Test plan
- Single word 8'hF0, LSB build, `IDLE_BIT` = 0: `out` = 0,0,0,0,1,1,1,1 in the cycles after edge k+1. `out_valid` is high for exactly 8 cycles. A downstream detector asserts its output after the fourth 0 and again after the fourth 1.
- Three words 8'h00, 8'hFF, 8'hA5 pushed back-to-back: `out_valid` is high for 24 consecutive cycles with no gap, and the bit order matches LSB-first.
- Push 6 words with DEPTH = 4 while the shifter is busy: `in_ready` falls after the FIFO holds 4. It rises one cycle after the next word-boundary pop. No word is lost or duplicated.
- Assert `reset` for one cycle at bit 3 of a word with 2 words queued:
  - the next cycle has `out` = `IDLE_BIT`, `out_valid` = 0, `level` = 0;
  - a fresh word afterwards serialises correctly.
- `SERIALIZER_MSB_FIRST_EN` build with word 8'h80: the first emitted bit is 1, followed by seven 0s.
- `IDLE_BIT` = 1 with no traffic: `out` stays 1 and `out_valid` stays 0 indefinitely.
